// File: rtl/datapath_unit.sv
// Single-cycle MIPS execute/memory/writeback datapath with 32x32 GPR file and data memory.
// Optional DP_TRACE_EN prints one line per committed register or memory write.
module datapath_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [1:0]  RegDst,
  input  logic        ALUSrc,
  input  logic [2:0]  ALUop,
  input  logic [1:0]  EXTop,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic [1:0]  Data,
  input  logic [31:0] PC,
  input  logic [31:0] PC_4,
  output logic [31:0] GPR_rs,
  output logic [31:0] offset,
  output logic        ZERO
);

  localparam int AW = $clog2(DM_WORDS);

  logic [31:0]   gpr [32];
  logic [31:0]   mem [DM_WORDS];
  logic [31:0]   rt_val;
  logic [31:0]   ext;
  logic [31:0]   opb;
  logic [31:0]   alu;
  logic [31:0]   rdata;
  logic [31:0]   wdata;
  logic [4:0]    wa;
  logic          we;
  logic [AW-1:0] maddr;

  assign GPR_rs = (rs == 5'd0) ? 32'h0 : gpr[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : gpr[rt];
  assign offset = {{16{imm[15]}}, imm};

  always_comb begin
    ext = {16'h0, imm};
    case (EXTop)
      2'b01:   ext = offset;
      2'b10:   ext = {imm, 16'h0};
      default: ext = {16'h0, imm};
    endcase
  end

  assign opb = ALUSrc ? ext : rt_val;

  always_comb begin
    alu = opb;
    case (ALUop)
      3'b000:  alu = GPR_rs + opb;
      3'b001:  alu = GPR_rs - opb;
      3'b010:  alu = GPR_rs | opb;
      3'b011:  alu = GPR_rs & opb;
      3'b100:  alu = {31'h0, $signed(GPR_rs) < $signed(opb)};
      3'b101:  alu = {31'h0, GPR_rs < opb};
      default: alu = opb;
    endcase
  end

  assign ZERO  = (alu == 32'h0);
  assign maddr = alu[AW+1:2];
  assign rdata = mem[maddr];

  always_comb begin
    wdata = alu;
    case (Data)
      2'b01:   wdata = rdata;
      2'b10:   wdata = PC_4;
      default: wdata = alu;
    endcase
  end

  // RegDst=11 maps to $0, which folds "no write" into the $0 drop
  always_comb begin
    wa = 5'd0;
    case (RegDst)
      2'b00:   wa = rt;
      2'b01:   wa = rd;
      2'b10:   wa = 5'd31;
      default: wa = 5'd0;
    endcase
  end

  assign we = RegWrite && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
      for (int j = 0; j < DM_WORDS; j++) mem[j] <= 32'h0;
    end else begin
      if (we) gpr[wa] <= wdata;
      if (MemWrite) mem[maddr] <= rt_val;
    end
  end

`ifdef DP_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we)
        $display("@%h: $%d <= %h", PC, wa, wdata);
      if (MemWrite)
        $display("@%h: *%h <= %h", PC, {alu[31:2], 2'b00}, rt_val);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed steps plus random
// instructions against an array-based reference model.
module tb_datapath_unit;

  localparam int DMW = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [1:0]  RegDst;
  logic        ALUSrc;
  logic [2:0]  ALUop;
  logic [1:0]  EXTop;
  logic        RegWrite, MemWrite;
  logic [1:0]  Data;
  logic [31:0] PC, PC_4;
  logic [31:0] GPR_rs, offset;
  logic        ZERO;

  logic [31:0] m_gpr [32];
  logic [31:0] m_mem [DMW];
  int checks = 0;
  int errors = 0;

  datapath_unit #(.DM_WORDS(DMW)) dut (
    .clk(clk), .reset(reset),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUop(ALUop), .EXTop(EXTop),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Data(Data),
    .PC(PC), .PC_4(PC_4),
    .GPR_rs(GPR_rs), .offset(offset), .ZERO(ZERO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [1:0] op,
                                        input logic [15:0] i);
    int s;
    s = $signed(i);
    if (op == 2'd1) return 32'(s);
    if (op == 2'd2) return 32'(i) * 32'h10000;
    return 32'(i);
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return (sa < sb) ? 32'd1 : 32'd0;
      3'd5: return (a < b) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  task automatic nop();
    reset = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    RegDst = 2'b11; ALUSrc = 0; ALUop = 0; EXTop = 0;
    RegWrite = 0; MemWrite = 0; Data = 0;
    PC = 32'h3000; PC_4 = 32'h3004;
  endtask

  // Check combinational outputs against the model, then commit one edge.
  task automatic step();
    logic [31:0] a, bt, b, al, wd;
    int wa, ma;
    a  = (rs == 0) ? 32'h0 : m_gpr[rs];
    bt = (rt == 0) ? 32'h0 : m_gpr[rt];
    b  = ALUSrc ? m_ext(EXTop, imm) : bt;
    al = m_alu(ALUop, a, b);
    ma = int'((al / 4) % DMW);
    wd = (Data == 2'd1) ? m_mem[ma] : (Data == 2'd2) ? PC_4 : al;
    wa = (RegDst == 2'd0) ? int'(rt) : (RegDst == 2'd1) ? int'(rd) :
         (RegDst == 2'd2) ? 31 : 0;
    #1;
    chk("gpr_rs", GPR_rs, a);
    chk("offset", offset, m_ext(2'd1, imm));
    chk("zero", {31'h0, ZERO}, {31'h0, al == 0});
    @(posedge clk);
    if (reset) begin
      foreach (m_gpr[i]) m_gpr[i] = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      if (RegWrite && wa != 0) m_gpr[wa] = wd;
      if (MemWrite) m_mem[ma] = bt;
    end
    @(negedge clk);
  endtask

  task automatic rd_reg(input int r, input logic [31:0] exp,
                        input string tag);
    nop();
    rs = 5'(r);
    #1 chk(tag, GPR_rs, exp);
    step();
  endtask

  task automatic ori(input int r, input logic [15:0] v);
    nop();
    rt = 5'(r); imm = v; ALUSrc = 1; ALUop = 3'd2;
    RegDst = 2'd0; RegWrite = 1;
    step();
  endtask

  initial begin
    foreach (m_gpr[i]) m_gpr[i] = 0;
    foreach (m_mem[i]) m_mem[i] = 0;
    nop();
    @(negedge clk);
    reset = 1;
    step();

    rd_reg(5, 32'h0, "reset_rs5");
    nop();
    ALUop = 3'd0;
    #1 chk("reset_zero", {31'h0, ZERO}, 32'h1);
    step();

    nop();
    imm = 16'h8001; ALUSrc = 1; ALUop = 3'd2;
    RegDst = 2'd0; rt = 8; RegWrite = 1;
    #1 chk("ori_offset", offset, 32'hFFFF8001);
    step();
    rd_reg(8, 32'h00008001, "ori_r8");

    ori(8, 16'h1234);
    ori(9, 16'h0004);
    nop();
    rs = 9; rt = 8; imm = 16'd8; EXTop = 1; ALUSrc = 1; MemWrite = 1;
    step();
    nop();
    rs = 9; rt = 10; imm = 16'd8; EXTop = 1; ALUSrc = 1;
    RegDst = 2'd0; Data = 2'd1; RegWrite = 1;
    step();
    rd_reg(10, 32'h1234, "lw_r10");
    nop();
    rt = 11; imm = 16'd12; ALUSrc = 1;
    RegDst = 2'd0; Data = 2'd1; RegWrite = 1;
    step();
    rd_reg(11, 32'h1234, "lw_word3");

    ori(8, 16'd7);
    ori(9, 16'd7);
    nop();
    rs = 8; rt = 9; ALUop = 3'd1;
    #1 chk("beq_eq", {31'h0, ZERO}, 32'h1);
    step();
    ori(9, 16'd6);
    nop();
    rs = 8; rt = 9; ALUop = 3'd1;
    #1 chk("beq_ne", {31'h0, ZERO}, 32'h0);
    step();

    nop();
    RegDst = 2'd2; Data = 2'd2; PC_4 = 32'h00003008; RegWrite = 1;
    step();
    rd_reg(31, 32'h00003008, "jal_r31");
    ori(0, 16'hFFFF);
    rd_reg(0, 32'h0, "r0_write");

    nop();
    rd = 12; RegDst = 2'd1; imm = 16'hFFF0; EXTop = 2'd1;
    ALUSrc = 1; ALUop = 3'd4; RegWrite = 1;
    step();
    rd_reg(12, 32'h0, "slt_neg_vs_0");
    nop();
    rd = 13; RegDst = 2'd1; imm = 16'hFFF0; EXTop = 2'd1;
    ALUSrc = 1; ALUop = 3'd5; RegWrite = 1;
    step();
    rd_reg(13, 32'h1, "sltu_0_vs_big");

    ori(4, 16'h0055);
    nop();
    rt = 4; imm = 16'h0100; ALUSrc = 1; MemWrite = 1;
    step();
    nop();
    rt = 4; imm = 16'h0077; ALUSrc = 1; ALUop = 3'd2;
    RegDst = 2'd0; RegWrite = 1; MemWrite = 1; reset = 1;
    step();
    rd_reg(4, 32'h0, "reset_r4");
    for (int i = 0; i < DMW; i++) begin
      nop();
      rt = 1; imm = 16'(i * 4); ALUSrc = 1;
      RegDst = 2'd0; Data = 2'd1; RegWrite = 1;
      step();
      rd_reg(1, 32'h0, "reset_mem");
    end

    for (int n = 0; n < 600; n++) begin
      reset    = 0;
      rs       = 5'($urandom_range(0, 31));
      rt       = 5'($urandom_range(0, 31));
      rd       = 5'($urandom_range(0, 31));
      imm      = 16'($urandom);
      RegDst   = 2'($urandom);
      ALUSrc   = 1'($urandom);
      ALUop    = 3'($urandom);
      EXTop    = 2'($urandom);
      RegWrite = ($urandom_range(0, 3) != 0);
      MemWrite = ($urandom_range(0, 2) == 0);
      Data     = 2'($urandom);
      PC       = $urandom;
      PC_4     = $urandom;
      step();
    end
    for (int r = 0; r < 32; r++) rd_reg(r, m_gpr[r], "final_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
